// File: rtl/weave_pkg.sv
// Shared types and width helpers for the weave pattern generator.
package weave_pkg;

    // Pattern source selected at start.
    typedef enum logic [1:0] {
        MODE_DRAFT = 2'd0,
        MODE_PLAIN = 2'd1,
        MODE_TWILL = 2'd2,
        MODE_SATIN = 2'd3
    } weave_mode_e;

    // Controller states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } weave_state_e;

    // Frame row counter / frame length width.
    localparam int unsigned ROW_W = 8;

    // Index width for an n-entry range, never narrower than one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Widths for the default configuration.
    localparam int unsigned DEF_WARP_W = 8;
    localparam int unsigned DEF_DEPTH  = 8;
    localparam int unsigned DEF_COL_W  = width_of(DEF_WARP_W);
    localparam int unsigned DEF_ADDR_W = width_of(DEF_DEPTH);

endpackage

// File: rtl/weave_pattern_gen_if.sv
// Draft load stream and pattern output stream of the weave generator.
interface weave_pattern_gen_if
    import weave_pkg::*;
#(
    parameter int unsigned WARP_W = 8
);
    localparam int unsigned COL_W = width_of(WARP_W);

    // Draft configuration stream
    logic              cfg_valid;
    logic              cfg_ready;
    logic [WARP_W-1:0] cfg_data;
    logic              cfg_last;

    // Pattern output stream
    logic              out_valid;
    logic              out_ready;
    logic              out_bit;
    logic [COL_W-1:0]  out_col;
    logic [ROW_W-1:0]  out_row;
    logic              out_eol;
    logic              out_eof;

    // Generator side
    modport master (
        input  cfg_valid, cfg_data, cfg_last, out_ready,
        output cfg_ready, out_valid, out_bit, out_col, out_row, out_eol, out_eof
    );

    // Driver / consumer side
    modport slave (
        output cfg_valid, cfg_data, cfg_last, out_ready,
        input  cfg_ready, out_valid, out_bit, out_col, out_row, out_eol, out_eof
    );

endinterface

// File: rtl/weave_draft_ram.sv
// DEPTH x WARP_W flop array holding the lift-plan draft.
// One synchronous write port, one combinational read port.
module weave_draft_ram
    import weave_pkg::*;
#(
    parameter  int unsigned WARP_W = 8,
    parameter  int unsigned DEPTH  = 8,
    localparam int unsigned ADDR_W = width_of(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WARP_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WARP_W-1:0] rdata
);

    logic [WARP_W-1:0] mem [DEPTH];

    // Row write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/weave_pattern_gen.sv
// Woven-cloth bit stream generator: one bit per warp/weft crossing,
// raster order (columns fastest), from a loaded draft or a built-in weave.
module weave_pattern_gen
    import weave_pkg::*;
#(
    parameter int unsigned WARP_W  = 8,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TWILL_P = 4,
    parameter int unsigned SATIN_P = 8,
    parameter int unsigned SATIN_S = 3
) (
    input  logic                clk,
    input  logic                rst,
    weave_pattern_gen_if.master bus,
    input  logic [1:0]          mode,
    input  logic [ROW_W-1:0]    frame_rows,
    input  logic                start,
    input  logic                abort,
    output logic                busy
);

    localparam int unsigned COL_W  = width_of(WARP_W);
    localparam int unsigned ADDR_W = width_of(DEPTH);
    localparam int unsigned NR_W   = ADDR_W + 1;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WARP_W - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    weave_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [NR_W-1:0]    num_rows_q, num_rows_d;
    weave_mode_e        mode_q, mode_d;
    logic [ROW_W-1:0]   frame_q, frame_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [ADDR_W-1:0]  drow_q, drow_d;

    logic               ram_we;
    logic [ADDR_W-1:0]  ram_waddr;
    logic [WARP_W-1:0]  draft_row;

    logic               cfg_fire;
    logic               xfer;
    logic               row_end;
    logic               frame_end;
    logic               start_ok;
    logic               draft_wrap;
    logic               pattern;
    logic [31:0]        col_ext, row_ext, twill_idx, satin_idx;

    weave_draft_ram #(
        .WARP_W (WARP_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (bus.cfg_data),
        .raddr (drow_q),
        .rdata (draft_row)
    );

    assign cfg_fire   = bus.cfg_valid && bus.cfg_ready;
    assign xfer       = bus.out_valid && bus.out_ready;
    assign row_end    = (col_q == COL_LAST);
    assign frame_end  = (frame_q != '0) && row_end && (row_q == frame_q - ROW_W'(1));
    assign start_ok   = !((weave_mode_e'(mode) == MODE_DRAFT) && (num_rows_q == '0));
    // Draft row wraps by compare against the loaded row count (no divider).
    assign draft_wrap = ({1'b0, drow_q} == num_rows_q - NR_W'(1));

    // Next-state, load pointer, run counters and draft write control.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        num_rows_d = num_rows_q;
        mode_d     = mode_q;
        frame_d    = frame_q;
        col_d      = col_q;
        row_d      = row_q;
        drow_d     = drow_q;
        ram_we     = 1'b0;
        ram_waddr  = ptr_q;

        case (state_q)
            S_IDLE: begin
                if (cfg_fire) begin
                    // A cfg beat always begins a fresh load at row 0 and beats start.
                    ram_we    = 1'b1;
                    ram_waddr = '0;
                    if (bus.cfg_last) begin
                        num_rows_d = NR_W'(1);
                    end else begin
                        ptr_d   = ADDR_W'(1);
                        state_d = S_LOAD;
                    end
                end else if (start && !abort && start_ok) begin
                    mode_d  = weave_mode_e'(mode);
                    frame_d = frame_rows;
                    col_d   = '0;
                    row_d   = '0;
                    drow_d  = '0;
                    state_d = S_RUN;
                end
            end

            S_LOAD: begin
                if (cfg_fire) begin
                    ram_we    = 1'b1;
                    ram_waddr = ptr_q;
                end
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cfg_fire) begin
                    if (bus.cfg_last || (ptr_q == ADDR_LAST)) begin
                        num_rows_d = {1'b0, ptr_q} + NR_W'(1);
                        state_d    = S_IDLE;
                    end else begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                end
            end

            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (xfer) begin
                    if (frame_end) begin
                        state_d = S_IDLE;
                    end
                    if (row_end) begin
                        col_d  = '0;
                        row_d  = row_q + ROW_W'(1);
                        drow_d = draft_wrap ? '0 : drow_q + ADDR_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            num_rows_q <= '0;
            mode_q     <= MODE_DRAFT;
            frame_q    <= '0;
            col_q      <= '0;
            row_q      <= '0;
            drow_q     <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            num_rows_q <= num_rows_d;
            mode_q     <= mode_d;
            frame_q    <= frame_d;
            col_q      <= col_d;
            row_q      <= row_d;
            drow_q     <= drow_d;
        end
    end

    // Built-in weave index arithmetic, truncated to the repeat mask.
    assign col_ext   = 32'(col_q);
    assign row_ext   = 32'(row_q);
    assign twill_idx = (col_ext + row_ext) & 32'(TWILL_P - 1);
    assign satin_idx = (col_ext * 32'(SATIN_S) + row_ext) & 32'(SATIN_P - 1);

    // Crossing value for the current column/row in the latched mode.
    always_comb begin
        pattern = 1'b0;
        case (mode_q)
            MODE_DRAFT: pattern = draft_row[col_q];
            MODE_PLAIN: pattern = col_q[0] ^ row_q[0];
            MODE_TWILL: pattern = (twill_idx < 32'(TWILL_P / 2));
            MODE_SATIN: pattern = (satin_idx == '0);
            default:    pattern = 1'b0;
        endcase
    end

    // Payload is a pure function of registered state, so it holds under backpressure.
    assign bus.cfg_ready = (state_q != S_RUN);
    assign bus.out_valid = (state_q == S_RUN);
    assign bus.out_bit   = bus.out_valid && pattern;
    assign bus.out_col   = col_q;
    assign bus.out_row   = row_q;
    assign bus.out_eol   = bus.out_valid && row_end;
    assign bus.out_eof   = bus.out_valid && frame_end;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_weave_pattern_gen.sv
// Scoreboard bench for weave_pattern_gen: stimulus pushes expected beats
// from a reference weave model; a monitor pops and compares on transfers.
module tb_weave_pattern_gen;
    import weave_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 8;
    localparam int unsigned TP = 4;
    localparam int unsigned SP = 8;
    localparam int unsigned SS = 3;
    localparam int unsigned CW = $clog2(W);

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [1:0] mode;
    logic [7:0] frame_rows;
    logic       busy;

    weave_pattern_gen_if #(.WARP_W(W)) bus ();

    weave_pattern_gen #(
        .WARP_W  (W),
        .DEPTH   (D),
        .TWILL_P (TP),
        .SATIN_P (SP),
        .SATIN_S (SS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .mode       (mode),
        .frame_rows (frame_rows),
        .start      (start),
        .abort      (abort),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          b;
        logic [CW-1:0] col;
        logic [7:0]    row;
        logic          eol;
        logic          eof;
    } beat_t;

    beat_t       exp_q[$];
    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned n_xfer = 0;

    // Consumer readiness: forced level or random.
    logic rand_ready  = 1'b0;
    logic ready_force = 1'b1;
    logic rnd         = 1'b1;
    assign bus.out_ready = rand_ready ? rnd : ready_force;

    always @(posedge clk) begin
        #1;
        rnd = ($urandom_range(0, 3) != 0);
    end

    // Reference model state: draft contents, committed row count, load progress.
    logic [W-1:0] m_draft [D];
    int unsigned  m_nrows = 0;
    int unsigned  m_ptr   = 0;

    function automatic logic model_bit(input int unsigned md, input int unsigned c, input int unsigned r);
        case (md)
            0:       return m_draft[r % m_nrows][c];
            1:       return ((c + r) % 2) == 1;
            2:       return ((c + r) % TP) < (TP / 2);
            default: return ((c * SS + r) % SP) == 0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every transferred beat and payload stability while stalled.
    beat_t held;
    logic  held_v = 1'b0;
    beat_t got;
    beat_t e;

    always @(negedge clk) begin
        if (rst || abort) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("hold", 32'({bus.out_valid, bus.out_bit, bus.out_col, bus.out_row}),
                      32'({1'b1, held.b, held.col, held.row}));
                held_v = 1'b0;
            end
            got = '{b: bus.out_bit, col: bus.out_col, row: bus.out_row,
                    eol: bus.out_eol, eof: bus.out_eof};
            if (bus.out_valid && bus.out_ready) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_extra: actual=beat col=%0d row=%0d required=no beat", got.col, got.row);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 32'(got), 32'(e));
                end
            end else if (bus.out_valid) begin
                held   = got;
                held_v = 1'b1;
            end
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic m_write(input logic [W-1:0] d, input logic last);
        m_draft[m_ptr] = d;
        m_ptr++;
        if (last || m_ptr == D) begin
            m_nrows = m_ptr;
            m_ptr   = 0;
        end
    endtask

    task automatic cfg_beat(input logic [W-1:0] d, input logic last);
        align();
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = d;
        bus.cfg_last  = last;
        @(negedge clk);
        check("cfg_ready", 32'(bus.cfg_ready), 32'd1);
        align();
        bus.cfg_valid = 1'b0;
        bus.cfg_last  = 1'b0;
        m_write(d, last);
    endtask

    task automatic push_beats(input int unsigned md, input int unsigned n, input int unsigned fr);
        beat_t x;
        for (int unsigned k = 0; k < n; k++) begin
            int unsigned c = k % W;
            int unsigned r = k / W;
            x.b   = model_bit(md, c, r);
            x.col = CW'(c);
            x.row = 8'(r % 256);
            x.eol = (c == W - 1);
            x.eof = (fr != 0) && (c == W - 1) && (r == fr - 1);
            exp_q.push_back(x);
        end
    endtask

    task automatic pulse_start(input int unsigned md, input int unsigned fr);
        align();
        mode       = 2'(md);
        frame_rows = 8'(fr);
        start      = 1'b1;
        align();
        start      = 1'b0;
    endtask

    task automatic start_run(input int unsigned md, input int unsigned fr);
        push_beats(md, W * fr, fr);
        pulse_start(md, fr);
    endtask

    task automatic drain(input string tag);
        int unsigned i;
        for (i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0) break;
        end
        if (i == 3000) begin
            checks++;
            errors++;
            $display("FAIL drain_%s: actual=%0d beats outstanding required=0", tag, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        check({"idle_after_", tag}, 32'({bus.out_valid, busy}), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        @(negedge clk);
        check(tag, 32'({bus.cfg_ready, busy, bus.out_valid, bus.out_bit, bus.out_eol,
                        bus.out_eof, bus.out_col, bus.out_row}),
              32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CW'(0), 8'd0}));
    endtask

    task automatic wait_xfers(input int unsigned target);
        for (int i = 0; i < 200 && n_xfer < target; i++) begin
            @(posedge clk);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: actual=time limit reached required=self-termination");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned base;
        logic [W-1:0] d9;

        rst           = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        mode          = 2'd0;
        frame_rows    = 8'd0;
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = '0;
        bus.cfg_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_reset("reset_state");

        // Draft start with nothing loaded is ignored.
        pulse_start(0, 2);
        @(negedge clk);
        check("no_draft_start", 32'({busy, bus.out_valid}), 32'd0);

        // Built-in weaves.
        start_run(1, 2);
        drain("plain");
        start_run(2, 2);
        drain("twill");
        start_run(3, 1);
        drain("satin");

        // Three-row draft, four emitted rows (wraps to row 0).
        cfg_beat(8'h0F, 1'b0);
        cfg_beat(8'hF0, 1'b0);
        cfg_beat(8'hAA, 1'b1);
        start_run(0, 4);
        drain("draft3");

        // cfg beat and start in the same cycle: load wins.
        align();
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 8'h3C;
        bus.cfg_last  = 1'b1;
        mode          = 2'd1;
        frame_rows    = 8'd1;
        start         = 1'b1;
        align();
        bus.cfg_valid = 1'b0;
        bus.cfg_last  = 1'b0;
        start         = 1'b0;
        m_write(8'h3C, 1'b1);
        @(negedge clk);
        check("cfg_over_start", 32'({busy, bus.out_valid}), 32'd0);
        start_run(0, 2);
        drain("draft1");

        // Nine beats at DEPTH=8: eighth completes the load, ninth restarts at row 0.
        for (int unsigned k = 0; k < D; k++) cfg_beat(W'($urandom), 1'b0);
        d9 = W'($urandom);
        cfg_beat(d9, 1'b0);
        @(negedge clk);
        check("load_busy", 32'(busy), 32'd1);
        pulse_start(1, 1);
        @(negedge clk);
        check("start_in_load", 32'({busy, bus.out_valid}), 32'b10);
        align();
        abort = 1'b1;
        align();
        abort = 1'b0;
        m_ptr = 0;
        @(negedge clk);
        check("abort_load", 32'(busy), 32'd0);
        start_run(0, 10);
        drain("draft8");

        // Backpressure at beat 3 for five cycles.
        base = n_xfer;
        start_run(2, 2);
        wait_xfers(base + 3);
        #1 ready_force = 1'b0;
        repeat (5) align();
        ready_force = 1'b1;
        drain("backpressure");

        // Abort a continuous draft run at beat 6; that beat is discarded.
        base = n_xfer;
        push_beats(0, 6, 0);
        pulse_start(0, 0);
        wait_xfers(base + 6);
        #1;
        ready_force = 1'b0;
        abort       = 1'b1;
        align();
        abort       = 1'b0;
        ready_force = 1'b1;
        @(negedge clk);
        check("abort_run", 32'({bus.out_valid, busy}), 32'd0);
        check("abort_queue", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        start_run(0, 3);
        drain("restart_draft");

        // Random modes and frame lengths under random backpressure.
        rand_ready = 1'b1;
        repeat (8) begin
            start_run($urandom_range(0, 3), $urandom_range(1, 4));
            drain("random");
        end
        rand_ready = 1'b0;

        // Reset during LOAD.
        cfg_beat(8'h55, 1'b0);
        cfg_beat(8'h66, 1'b0);
        align();
        rst = 1'b1;
        align();
        rst = 1'b0;
        m_nrows = 0;
        m_ptr   = 0;
        check_reset("rst_load");
        pulse_start(0, 1);
        @(negedge clk);
        check("rst_load_start", 32'({busy, bus.out_valid}), 32'd0);

        // Reset during RUN (consumer stalled, so no beats transfer).
        cfg_beat(8'h81, 1'b1);
        ready_force = 1'b0;
        pulse_start(1, 0);
        @(negedge clk);
        check("run_busy", 32'({busy, bus.out_valid}), 32'b11);
        align();
        rst = 1'b1;
        align();
        rst = 1'b0;
        m_nrows = 0;
        ready_force = 1'b1;
        check_reset("rst_run");
        pulse_start(0, 1);
        @(negedge clk);
        check("rst_run_start", 32'({busy, bus.out_valid}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/weave_pattern_gen.md
Name: weave_pattern_gen

Overview:
- Parametrised successor to the first weaving tile. Generates a woven-cloth bit stream: one bit per warp/weft crossing, 1 = warp over weft.
- Pattern source is either a lift-plan draft loaded over a config stream, or one of three built-in weaves: plain, twill, satin.
- Sits between the TT pin wrapper and the pixel/LED output stage. Output is a valid/ready stream in raster order: columns fastest, then rows.

Parameters:
- WARP_W, 8: warp threads per row (columns). Power of two, 2..32.
- DEPTH, 8: maximum draft rows stored. Power of two, 2..16.
- TWILL_P, 4: twill repeat length. Power of two, at most WARP_W.
- SATIN_P, 8: satin repeat length. Power of two.
- SATIN_S, 3: satin step. Odd, less than SATIN_P.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  draft row beat valid
- cfg_ready  out  1  draft beat accepted when high together with cfg_valid
- cfg_data  in  WARP_W  one lift-plan row; bit c = warp c lifted
- cfg_last  in  1  final draft row
- mode  in  2  0 = draft, 1 = plain, 2 = twill, 3 = satin; sampled at start
- frame_rows  in  8  rows to emit; 0 = continuous; sampled at start
- start  in  1  single-cycle start request
- abort  in  1  stop generation
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts the beat
- out_bit  out  1  crossing value
- out_col  out  clog2(WARP_W)  column index
- out_row  out  8  frame row index
- out_eol  out  1  beat is the last column of a row
- out_eof  out  1  beat is the last beat of the frame (never asserted in continuous mode)
- busy  out  1  FSM is not in IDLE

Behaviour:
- Reset: FSM goes to IDLE, num_rows = 0. All outputs are 0 except cfg_ready, which is 1. Draft RAM contents are don't-care after reset.
- FSM states and transitions:
  - IDLE: cfg_ready = 1. An accepted cfg beat writes row 0, sets ptr = 1 and moves to LOAD, or completes the load immediately if cfg_last is set.
  - LOAD: cfg_ready = 1. Each accepted beat writes row[ptr]. cfg_last, or writing row DEPTH-1, sets num_rows = ptr+1 and returns to IDLE. Beats beyond DEPTH cannot occur because the load stops at DEPTH-1.
  - RUN: cfg_ready = 0.
- Loading in IDLE overwrites the previous draft. num_rows is updated only when the load completes.
- start: honoured only in IDLE with no cfg beat accepted in the same cycle; the cfg beat wins. In mode 0 with num_rows == 0, start is ignored and the FSM stays IDLE. When honoured, mode and frame_rows are latched, col = row = 0, and the FSM enters RUN. out_valid rises the next cycle (latency 1).
- start in LOAD or RUN is ignored.
- Output handshake: a beat transfers when out_valid && out_ready. Payload is held stable while out_valid && !out_ready. out_valid never drops without a transfer, except on abort or rst.
- On each transfer:
  - col increments. At WARP_W-1 it wraps to 0 and row increments.
  - The draft row index increments and wraps at num_rows-1 (explicit compare, no modulo divider).
  - out_row wraps 255 -> 0 in continuous mode.
- Frame end: the transfer with col = WARP_W-1 and row = frame_rows-1 carries out_eof = 1. The FSM returns to IDLE on that cycle, and out_valid is 0 the next cycle.
- out_bit by mode (c = col, r = row):
  - draft: draft[r mod num_rows][c]
  - plain: c XOR r, LSBs
  - twill: ((c + r) & (TWILL_P-1)) < TWILL_P/2
  - satin: ((c*SATIN_S + r) & (SATIN_P-1)) == 0
  - All arithmetic is unsigned and truncated to the mask width.
- abort: in RUN, the FSM goes to IDLE next cycle and out_valid drops. A pending unaccepted beat is discarded; draft and num_rows are kept. In LOAD, the FSM goes to IDLE and num_rows is unchanged. In IDLE, abort has no effect.
- abort and start in the same cycle: abort wins.
- rst mid-operation: immediate return to the reset state on the next edge.

Decomposition:
- Package weave_pkg holds:
  - mode enum: MODE_DRAFT, MODE_PLAIN, MODE_TWILL, MODE_SATIN
  - FSM state enum: S_IDLE, S_LOAD, S_RUN
  - clog2-derived width constants
- One sub-module, weave_draft_ram: DEPTH x WARP_W flop array with one write port and one combinational read port. Bit select by col happens in the parent.

Test Plan:
- Plain mode, frame_rows = 2, out_ready = 1: 16 beats. Row 0 bits are 0101_0101 (c = 0 first), row 1 bits are 1010_1010. out_eol on beats 7 and 15, out_eof on beat 15 only, busy low afterwards.
- Load 3 draft rows 0x0F, 0xF0, 0xAA with cfg_last on the third, then draft mode with frame_rows = 4: rows emitted are 0x0F, 0xF0, 0xAA, 0x0F (wrap). With a 9-beat load at DEPTH = 8, the ninth beat starts a fresh load at row 0.
- Twill, TWILL_P = 4: row 0 bits are 1100_1100 and row 1 bits are 1001_1001 (c = 0 first; each row shifts the pattern by one column). Satin row 0 has bits only at c = 0 (and c = 8, out of range at WARP_W = 8).
- Backpressure: drop out_ready for 5 cycles at beat 3. out_bit, out_col and out_row must stay constant, and no beat may be skipped or duplicated.
- abort at beat 6 of a continuous run: out_valid is 0 the next cycle and busy is 0. A restart in draft mode reuses the stored draft. start in mode 0 after reset with no draft loaded: busy stays 0.
- rst asserted during LOAD and during RUN: all outputs return to reset values next cycle, cfg_ready = 1, and a subsequent draft-mode start is ignored.
